// File: rtl/uart_status_reporter_if.sv
// Byte-level handshake between the status reporter and uart_tx.
// master drives o_tx_start/o_tx_data; slave returns i_tx_busy/i_tx_done.
interface uart_status_reporter_if;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic       i_tx_done;

  modport master (
    output o_tx_start,
    output o_tx_data,
    input  i_tx_busy,
    input  i_tx_done
  );

  modport slave (
    input  o_tx_start,
    input  o_tx_data,
    output i_tx_busy,
    output i_tx_done
  );
endinterface

// File: rtl/uart_status_reporter.sv
// Sends "<mode><4 digits>\r\n" status frames to uart_tx on mode edges/requests/period.
// Ports: clk, reset (async high), i_count, i_run_on, i_clr_on, i_report, tx (master), o_busy.
module uart_status_reporter #(
  parameter int COUNT_W       = 14,
  parameter int REPORT_PERIOD = 100_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_W-1:0]     i_count,
  input  logic                   i_run_on,
  input  logic                   i_clr_on,
  input  logic                   i_report,
  uart_status_reporter_if.master tx,
  output logic                   o_busy
);

  typedef enum logic [1:0] {IDLE, CONV, SEND, WAIT} state_t;

  localparam int                 CW     = $clog2(COUNT_W + 1);
  localparam logic [COUNT_W-1:0] SAT    = COUNT_W'(9999);
  localparam bit                 PER_EN = (REPORT_PERIOD > 0);
  localparam logic [31:0]        PLAST  = 32'(REPORT_PERIOD - 1);

  state_t             state, state_n;
  logic               pending, pending_n;
  logic [31:0]        per_cnt, per_cnt_n;
  logic               prev_run, prev_clr;
  logic [7:0]         mode, mode_n;
  logic [COUNT_W-1:0] bin, bin_n;
  logic [15:0]        bcd, bcd_n, adj;
  logic [CW-1:0]      step, step_n;
  logic [2:0]         idx, idx_n;
  logic               tx_start, tx_start_n;
  logic [7:0]         tx_data, tx_data_n;
  logic [7:0]         byte_sel;
  logic               per_hit, trig;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign per_hit = PER_EN && i_run_on && (per_cnt == PLAST);
  assign trig    = (i_run_on ^ prev_run) | (i_clr_on & ~prev_clr)
                 | i_report | per_hit;

  always_comb begin
    byte_sel = 8'h0A;
    unique case (idx)
      3'd0:    byte_sel = mode;
      3'd1:    byte_sel = {4'h3, bcd[15:12]};
      3'd2:    byte_sel = {4'h3, bcd[11:8]};
      3'd3:    byte_sel = {4'h3, bcd[7:4]};
      3'd4:    byte_sel = {4'h3, bcd[3:0]};
      3'd5:    byte_sel = 8'h0D;
      default: byte_sel = 8'h0A;
    endcase
  end

  always_comb begin
    state_n    = state;
    pending_n  = pending | trig;
    per_cnt_n  = per_cnt + 32'd1;
    mode_n     = mode;
    bin_n      = bin;
    bcd_n      = bcd;
    step_n     = step;
    idx_n      = idx;
    tx_start_n = 1'b0;
    tx_data_n  = tx_data;
    adj        = add3(bcd);

    if (!PER_EN || !i_run_on || per_hit) per_cnt_n = '0;

    unique case (state)
      IDLE: begin
        if (pending) begin
          // A trigger in this same cycle re-arms for a follow-up frame
          pending_n = trig;
          if (i_clr_on)      mode_n = "C";
          else if (i_run_on) mode_n = "R";
          else               mode_n = "S";
          bin_n   = (32'(i_count) > 32'd9999) ? SAT : i_count;
          bcd_n   = '0;
          step_n  = '0;
          state_n = CONV;
        end
      end
      CONV: begin
        bcd_n  = {adj[14:0], bin[COUNT_W-1]};
        bin_n  = bin << 1;
        step_n = step + CW'(1);
        if (step == CW'(COUNT_W - 1)) begin
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (!tx.i_tx_busy) begin
          tx_start_n = 1'b1;
          tx_data_n  = byte_sel;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (tx.i_tx_done) begin
          if (idx == 3'd6) state_n = IDLE;
          else begin
            idx_n   = idx + 3'd1;
            state_n = SEND;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      per_cnt  <= '0;
      prev_run <= 1'b0;
      prev_clr <= 1'b0;
      mode     <= 8'h00;
      bin      <= '0;
      bcd      <= '0;
      step     <= '0;
      idx      <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_n;
      pending  <= pending_n;
      per_cnt  <= per_cnt_n;
      prev_run <= i_run_on;
      prev_clr <= i_clr_on;
      mode     <= mode_n;
      bin      <= bin_n;
      bcd      <= bcd_n;
      step     <= step_n;
      idx      <= idx_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
    end
  end

  assign tx.o_tx_start = tx_start;
  assign tx.o_tx_data  = tx_data;
  assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_status_reporter.sv
// Directed bench for uart_status_reporter with a small uart_tx model.
// Captures every started byte and checks frames, timing and handshake rules.
module tb_uart_status_reporter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] count = '0;
  logic        run_on = 1'b0;
  logic        clr_on = 1'b0;
  logic        report = 1'b0;
  logic        busy;

  logic        m_busy, m_done, outst;
  logic        hold_busy = 1'b0;
  int          lat = 2;
  int          m_cnt;
  int          viol = 0;
  logic [7:0]  q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  uart_status_reporter_if bus();

  uart_status_reporter #(
    .COUNT_W(14),
    .REPORT_PERIOD(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_count(count),
    .i_run_on(run_on),
    .i_clr_on(clr_on),
    .i_report(report),
    .tx(bus),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  assign bus.i_tx_busy = m_busy | hold_busy;
  assign bus.i_tx_done = m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      outst  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (bus.o_tx_start) begin
        q.push_back(bus.o_tx_data);
        if (outst || bus.i_tx_busy) viol <= viol + 1;
        outst  <= 1'b1;
        m_busy <= 1'b1;
        m_cnt  <= lat;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          outst  <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bytes(input int n, input int maxc);
    for (int i = 0; i < maxc && q.size() < n; i++) @(negedge clk);
  endtask

  task automatic pulse_report();
    report = 1'b1;
    @(negedge clk);
    report = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    n_chk++;
    if (bus.o_tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start got %b want 0", bus.o_tx_start);
    end
    n_chk++;
    if (bus.o_tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data got %h want 00", bus.o_tx_data);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    reset = 1'b0;
    idle(40);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_quiet got %0d bytes want 0", q.size());
    end
  endtask

  task automatic test_stopped_report();
    logic [7:0] exp [7];
    logic [7:0] got;
    int n, v0;
    exp = '{"S", "0", "0", "4", "2", 8'h0D, 8'h0A};
    lat = 2;
    count = 14'd42;
    q.delete();
    v0 = viol;
    pulse_report();
    n = 0;
    while (!bus.o_tx_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL stop_latency got %0d want 16", n);
    end
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_busy got %b want 1", busy);
    end
    wait_bytes(7, 300);
    idle(30);
    n_chk++;
    if (q.size() != 7) begin
      n_fail++;
      $display("FAIL stop_len got %0d want 7", q.size());
    end
    for (int i = 0; i < 7; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      n_chk++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL stop_byte%0d got %h want %h", i, got, exp[i]);
      end
    end
    n_chk++;
    if (viol != v0) begin
      n_fail++;
      $display("FAIL stop_handshake got %0d overlaps want 0", viol - v0);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle got %b want 0", busy);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp [7];
    logic [7:0] got;
    exp = '{"S", "9", "9", "9", "9", 8'h0D, 8'h0A};
    count = 14'd16383;
    q.delete();
    pulse_report();
    wait_bytes(7, 300);
    idle(30);
    for (int i = 0; i < 7; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      n_chk++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL sat_byte%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_run_period();
    logic [7:0] exp [7];
    logic [7:0] got;
    exp = '{"R", "0", "0", "0", "7", 8'h0D, 8'h0A};
    lat = 0;
    count = 14'd7;
    q.delete();
    run_on = 1'b1;
    idle(230);
    run_on = 1'b0;
    idle(150);
    n_chk++;
    if (q.size() != 42) begin
      n_fail++;
      $display("FAIL run_len got %0d want 42", q.size());
    end
    for (int i = 0; i < 7; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      n_chk++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL run_byte%0d got %h want %h", i, got, exp[i]);
      end
    end
    for (int f = 1; f < 5; f++) begin
      got = (7 * f < q.size()) ? q[7 * f] : 8'hxx;
      n_chk++;
      if (got !== "R") begin
        n_fail++;
        $display("FAIL run_frame%0d got %h want 52", f, got);
      end
    end
    got = (35 < q.size()) ? q[35] : 8'hxx;
    n_chk++;
    if (got !== "S") begin
      n_fail++;
      $display("FAIL run_stop_frame got %h want 53", got);
    end
    lat = 2;
  endtask

  task automatic test_clr_collapse();
    logic [7:0] exp [7];
    logic [7:0] got;
    exp = '{"C", "1", "2", "3", "4", 8'h0D, 8'h0A};
    count = 14'd1234;
    q.delete();
    clr_on = 1'b1;
    wait_bytes(2, 100);
    repeat (3) begin
      pulse_report();
      idle(3);
    end
    wait_bytes(14, 400);
    idle(100);
    n_chk++;
    if (q.size() != 14) begin
      n_fail++;
      $display("FAIL clr_len got %0d want 14", q.size());
    end
    for (int i = 0; i < 7; i++) begin
      got = (i < q.size()) ? q[i] : 8'hxx;
      n_chk++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL clr_byte%0d got %h want %h", i, got, exp[i]);
      end
    end
    got = (7 < q.size()) ? q[7] : 8'hxx;
    n_chk++;
    if (got !== "C") begin
      n_fail++;
      $display("FAIL clr_second got %h want 43", got);
    end
    clr_on = 1'b0;
    idle(100);
    n_chk++;
    if (q.size() != 14) begin
      n_fail++;
      $display("FAIL clr_fall got %0d bytes want 14", q.size());
    end
  endtask

  task automatic test_busy_hold();
    logic [7:0] got;
    int v0;
    count = 14'd5;
    q.delete();
    v0 = viol;
    hold_busy = 1'b1;
    pulse_report();
    idle(60);
    n_chk++;
    if (q.size() != 0 || bus.o_tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_nostart got %0d bytes want 0", q.size());
    end
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_busy got %b want 1", busy);
    end
    hold_busy = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.o_tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release got %b want 1", bus.o_tx_start);
    end
    @(negedge clk);
    n_chk++;
    if (bus.o_tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_pulse got %b want 0", bus.o_tx_start);
    end
    wait_bytes(7, 300);
    idle(30);
    got = (4 < q.size()) ? q[4] : 8'hxx;
    n_chk++;
    if (q.size() != 7 || got !== "5") begin
      n_fail++;
      $display("FAIL hold_frame got %0d bytes digit %h want 7 bytes digit 35",
               q.size(), got);
    end
    n_chk++;
    if (viol != v0) begin
      n_fail++;
      $display("FAIL hold_handshake got %0d overlaps want 0", viol - v0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    int n, c;
    count = 14'd42;
    q.delete();
    pulse_report();
    n = 0;
    c = 0;
    while (n < 4 && c < 400) begin
      @(negedge clk);
      c++;
      if (bus.o_tx_start) n++;
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (bus.o_tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_start got %b want 0", bus.o_tx_start);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_busy got %b want 0", busy);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(100);
    n_chk++;
    if (q.size() != 3) begin
      n_fail++;
      $display("FAIL rmid_abandon got %0d bytes want 3", q.size());
    end
    pulse_report();
    wait_bytes(10, 300);
    idle(30);
    got = (3 < q.size()) ? q[3] : 8'hxx;
    n_chk++;
    if (q.size() != 10 || got !== "S") begin
      n_fail++;
      $display("FAIL rmid_new got %0d bytes first %h want 10 bytes first 53",
               q.size(), got);
    end
  endtask

  initial begin
    test_reset();
    test_stopped_report();
    test_saturate();
    test_run_period();
    test_clr_collapse();
    test_busy_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
